db_qp_ram_ctrl: RTL and testbench

Access controller for the deblocking QP store: the initiator side of the 64x20 single-port QP RAM. It accepts QP record writes from the prediction/TQ side and lookup reads from the deblocking filter. It arbitrates both onto the RAM's single port with low-active strobes, returns read data with a fixed two-cycle latency, and can sweep-clear all 64 entries at LCU start.

---
 rtl/db_qp_ram_ctrl.sv | 141 ++++++++++++++
 tb/tb_db_qp_ram_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/db_qp_ram_ctrl.sv
// Initiator side of the deblocking QP store. It arbitrates write and lookup traffic
// onto the single-port RAM and can sweep-clear every entry at LCU start.
module db_qp_ram_ctrl #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_val_i,
  output logic              wr_rdy_o,
  input  logic [ADDR_W-1:0] wr_adr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  input  logic              rd_req_i,
  output logic              rd_rdy_o,
  input  logic [ADDR_W-1:0] rd_adr_i,
  output logic              rd_val_o,
  output logic [DATA_W-1:0] rd_dat_o,
  input  logic              clr_i,
  output logic              clr_done_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [DATA_W-1:0] ram_wr_dat_o,
  input  logic [DATA_W-1:0] ram_rd_dat_i
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ADR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DAT_ZERO = {DATA_W{1'b0}};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic                r_clr_done;
  logic                r_rd_pend;
  logic                r_rd_val;
  logic [DATA_W-1:0]   r_rd_dat;

  logic                w_idle;
  logic                w_rd_acc;
  logic                w_wr_acc;

  // Handshake: reads always win the port over a colliding write.
  always_comb begin
    w_idle   = 1'b0;
    w_rd_acc = 1'b0;
    w_wr_acc = 1'b0;
    if (!rst && (r_state == S_IDLE)) begin
      w_idle   = 1'b1;
      w_rd_acc = rd_req_i;
      w_wr_acc = wr_val_i & ~rd_req_i;
    end else begin
      w_idle   = 1'b0;
    end
    rd_rdy_o = w_idle;
    wr_rdy_o = w_idle & ~rd_req_i;
  end

  // RAM strobes follow the accepted access in the same cycle.
  always_comb begin
    ram_cen_o    = 1'b1;
    ram_wen_o    = 1'b1;
    ram_adr_o    = ADR_ZERO;
    ram_wr_dat_o = DAT_ZERO;
    if (rst) begin
      ram_cen_o = 1'b1;
    end else if (r_state == S_CLEAR) begin
      ram_cen_o = 1'b0;
      ram_wen_o = 1'b0;
      ram_adr_o = r_cnt;
    end else if (w_rd_acc) begin
      ram_cen_o = 1'b0;
      ram_adr_o = rd_adr_i;
    end else if (w_wr_acc) begin
      ram_cen_o    = 1'b0;
      ram_wen_o    = 1'b0;
      ram_adr_o    = wr_adr_i;
      ram_wr_dat_o = wr_dat_i;
    end else begin
      ram_cen_o = 1'b1;
    end
  end

  // Read return pipeline, clear sweep sequencing and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= ADR_ZERO;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_val   <= 1'b0;
      r_rd_dat   <= DAT_ZERO;
    end else begin
      r_rd_pend  <= w_rd_acc;
      r_rd_val   <= r_rd_pend;
      r_clr_done <= 1'b0;
      if (r_rd_pend) begin
        r_rd_dat <= ram_rd_dat_i;
      end
      case (r_state)
        S_IDLE: begin
          if (clr_i) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= ADR_ZERO;
          end
        end
        S_CLEAR: begin
          // A clr_i pulse here is deliberately ignored; the sweep never restarts.
          if (r_cnt == CNT_LAST) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b1;
            r_cnt      <= ADR_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= ADR_ZERO;
        end
      endcase
    end
  end

  assign rd_val_o   = r_rd_val;
  assign rd_dat_o   = r_rd_dat;
  assign clr_done_o = r_clr_done;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_db_qp_ram_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-indexed reference model of the QP store and its clear sweep.
module tb_db_qp_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_val_i, wr_rdy_o, rd_req_i, rd_rdy_o, rd_val_o;
  logic [5:0]  wr_adr_i, rd_adr_i, ram_adr_o;
  logic [19:0] wr_dat_i, rd_dat_o, ram_wr_dat_o, ram_rd_dat_i;
  logic        clr_i, clr_done_o, busy_o, ram_cen_o, ram_wen_o;

  db_qp_ram_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_val_i(wr_val_i), .wr_rdy_o(wr_rdy_o), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
    .rd_req_i(rd_req_i), .rd_rdy_o(rd_rdy_o), .rd_adr_i(rd_adr_i),
    .rd_val_o(rd_val_o), .rd_dat_o(rd_dat_o),
    .clr_i(clr_i), .clr_done_o(clr_done_o), .busy_o(busy_o),
    .ram_adr_o(ram_adr_o), .ram_cen_o(ram_cen_o), .ram_wen_o(ram_wen_o),
    .ram_wr_dat_o(ram_wr_dat_o), .ram_rd_dat_i(ram_rd_dat_i)
  );

  always #5 clk = ~clk;

  // Single-port RAM: data appears the cycle after a read strobe.
  logic [19:0] ram_mem [64];
  logic [19:0] ram_q;
  always @(posedge clk) begin
    if (!ram_cen_o) begin
      if (!ram_wen_o) ram_mem[ram_adr_o] <= ram_wr_dat_o;
      else            ram_q <= ram_mem[ram_adr_o];
    end
  end
  assign ram_rd_dat_i = ram_q;

  typedef struct {int due; logic [19:0] d;} rd_t;
  logic [19:0] ref_mem [64];
  rd_t         rq [$];
  int          cyc = 0;
  int          clr_start = -1;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus, checked against the model at the falling edge.
  task automatic step(input bit rd, input int ra, input bit wr, input int wa,
                      input logic [19:0] wd, input bit clr);
    bit   busy_m;
    bit   exp_val;
    int   cidx;
    rd_t  e;
    rd_req_i = rd; rd_adr_i = ra[5:0];
    wr_val_i = wr; wr_adr_i = wa[5:0]; wr_dat_i = wd;
    clr_i = clr;
    @(negedge clk);
    busy_m = (clr_start >= 0) && (cyc > clr_start) && (cyc <= clr_start + 64);
    cidx   = cyc - clr_start - 1;
    chk("busy", busy_o, busy_m);
    chk("clr_done", clr_done_o, (clr_start >= 0) && (cyc == clr_start + 65));
    exp_val = (rq.size() > 0) && (rq[0].due == cyc);
    chk("rd_val", rd_val_o, exp_val);
    if (exp_val) begin
      chk("rd_dat", rd_dat_o, rq[0].d);
      void'(rq.pop_front());
    end
    chk("rd_rdy", rd_rdy_o, !busy_m);
    chk("wr_rdy", wr_rdy_o, !busy_m && !rd);
    if (busy_m) begin
      chk("clr_cen", ram_cen_o, 0); chk("clr_wen", ram_wen_o, 0);
      chk("clr_adr", ram_adr_o, cidx); chk("clr_dat", ram_wr_dat_o, 0);
      ref_mem[cidx] = 20'h0;
    end else if (rd) begin
      chk("rd_cen", ram_cen_o, 0); chk("rd_wen", ram_wen_o, 1);
      chk("rd_adr", ram_adr_o, ra);
      e.due = cyc + 2; e.d = ref_mem[ra];
      rq.push_back(e);
    end else if (wr) begin
      chk("wr_cen", ram_cen_o, 0); chk("wr_wen", ram_wen_o, 0);
      chk("wr_adr", ram_adr_o, wa); chk("wr_dat", ram_wr_dat_o, wd);
      ref_mem[wa] = wd;
    end else begin
      chk("nop_cen", ram_cen_o, 1); chk("nop_wen", ram_wen_o, 1);
      chk("nop_adr", ram_adr_o, 0); chk("nop_dat", ram_wr_dat_o, 0);
    end
    if (clr && !busy_m) clr_start = cyc;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 20'h0, 0);
  endtask

  // One cycle with reset held high; everything in flight is dropped.
  task automatic do_reset();
    rst = 1'b1;
    rd_req_i = 1'b0; wr_val_i = 1'b0; clr_i = 1'b0;
    @(negedge clk);
    chk("rst_rd_rdy", rd_rdy_o, 0); chk("rst_wr_rdy", wr_rdy_o, 0);
    chk("rst_cen", ram_cen_o, 1);   chk("rst_wen", ram_wen_o, 1);
    chk("rst_adr", ram_adr_o, 0);   chk("rst_dat", ram_wr_dat_o, 0);
    chk("rst_rd_val", rd_val_o, 0); chk("rst_rd_dat", rd_dat_o, 0);
    chk("rst_busy", busy_o, 0);     chk("rst_clr_done", clr_done_o, 0);
    rq.delete();
    clr_start = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; rd_req_i = 1'b0; wr_val_i = 1'b0; clr_i = 1'b0;
    rd_adr_i = 6'd0; wr_adr_i = 6'd0; wr_dat_i = 20'h0;
    #1;
    do_reset();
    for (int a = 0; a < 64; a++) step(0, 0, 1, a, 20'h0, 0);

    // Write then read back.
    step(0, 0, 1, 5, 20'hABCDE, 0);
    step(1, 5, 0, 0, 20'h0, 0);
    idle(3);

    // Collision: read wins, write waits one cycle.
    step(1, 3, 1, 4, 20'h12345, 0);
    step(0, 0, 1, 4, 20'h12345, 0);
    step(1, 4, 0, 0, 20'h0, 0);
    idle(3);

    // Fill with addr+1, then full clear sweep.
    for (int a = 0; a < 64; a++) step(0, 0, 1, a, 20'(a + 1), 0);
    step(0, 0, 0, 0, 20'h0, 1);
    idle(66);
    step(1, 0, 0, 0, 20'h0, 0);
    step(1, 31, 0, 0, 20'h0, 0);
    step(1, 63, 0, 0, 20'h0, 0);
    idle(3);

    // Back-to-back reads at the address extremes.
    step(0, 0, 1, 63, 20'hFFFFF, 0);
    step(0, 0, 1, 0, 20'h00001, 0);
    step(1, 63, 0, 0, 20'h0, 0);
    step(1, 0, 0, 0, 20'h0, 0);
    idle(3);

    // Reset in the middle of a clear sweep at cnt=20.
    for (int a = 0; a < 64; a++) step(0, 0, 1, a, 20'(a + 1), 0);
    step(0, 0, 0, 0, 20'h0, 1);
    while (cyc < clr_start + 21) idle(1);
    do_reset();
    step(1, 19, 0, 0, 20'h0, 0);
    step(1, 20, 0, 0, 20'h0, 0);
    idle(3);

    // Second clr_i pulse mid-sweep is ignored.
    step(0, 0, 0, 0, 20'h0, 1);
    while (cyc < clr_start + 11) idle(1);
    step(0, 0, 0, 0, 20'h0, 1);
    idle(58);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else step(1'($urandom_range(0, 1)), $urandom_range(0, 63),
                1'($urandom_range(0, 1)), $urandom_range(0, 63),
                20'($urandom), r < 3);
    end
    idle(70);
    chk("rd_queue_drained", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
